// File: rtl/spine_pkg.sv
// Shared definitions for the spine router schedulers.
//   - Header flit field positions (LEN, DEST).
//   - Arbiter state encoding.
//   - Index-width helper used to size requester indices and counters.
package spine_pkg;

   localparam int unsigned LEN_MSB  = 7;
   localparam int unsigned LEN_LSB  = 4;
   localparam int unsigned DEST_MSB = 11;
   localparam int unsigned DEST_LSB = 8;

   // Width of grant_id / round-robin pointer seen by the router.
   localparam int unsigned GID_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } arb_state_t;

   // Bits needed to index n items; never less than one.
   function automatic int unsigned idx_width(input int unsigned n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

   function automatic logic [LEN_MSB-LEN_LSB:0] flit_len(input logic [15:0] f);
      return f[LEN_MSB:LEN_LSB];
   endfunction

   function automatic logic [DEST_MSB-DEST_LSB:0] flit_dest(input logic [15:0] f);
      return f[DEST_MSB:DEST_LSB];
   endfunction

endpackage

// File: rtl/spine_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     [NUM_REQ]  request vector
//   ptr     [IW]       last winner; search starts at ptr+1
//   winner  [IW]       first set request after ptr, wrapping modulo NUM_REQ
//   any_req            at least one request is set
// ptr must be < NUM_REQ; the wrap is a single subtract, so no index
// ever reaches NUM_REQ even when NUM_REQ is not a power of two.
module rr_pick
   import spine_pkg::*;
#(
   parameter int unsigned NUM_REQ = 11,
   parameter int unsigned IW      = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      winner,
   output logic               any_req
);

   localparam int unsigned SW = idx_width(NUM_REQ);

   int unsigned idx;

   // Scan from the farthest offset down to ptr+1 so the nearest set
   // request after ptr is the last (winning) assignment.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr) + (NUM_REQ - k);
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[SW'(idx)]) winner = IW'(idx);
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/spine_out_arbiter.sv
// spine_out_arbiter: per-output-port packet scheduler.
// Round-robin among NUM_REQ requesters at packet granularity; the
// winner keeps the grant from header through last body flit.
//   clk          system clock
//   reset        asynchronous active-low reset
//   req_valid    [NUM_REQ]          requester i presents a flit
//   req_data     [NUM_REQ*DWIDTH]   flit of requester i at [i*DWIDTH +: DWIDTH]
//   req_ready    [NUM_REQ]          combinational pop of the accepted requester
//   out_full                        downstream FIFO full
//   out_data     [DWIDTH]           registered forwarded flit
//   out_valid                       registered, out_data valid
//   grant_valid                     packet in progress (BODY)
//   grant_id     [4]                current or last owner
//   err_timeout                     one-cycle pulse on packet abort
module spine_out_arbiter
   import spine_pkg::*;
#(
   parameter int unsigned NUM_REQ = 11,
   parameter int unsigned DWIDTH  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DWIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      out_full,
   output logic [DWIDTH-1:0]         out_data,
   output logic                      out_valid,
   output logic                      grant_valid,
   output logic [GID_W-1:0]          grant_id,
   output logic                      err_timeout
);

   localparam int unsigned LW = LEN_MSB - LEN_LSB + 1;
   localparam int unsigned SW = idx_width(NUM_REQ);
   localparam int unsigned CW = idx_width(TIMEOUT);
   localparam logic [GID_W-1:0] PTR_RST   = GID_W'(NUM_REQ - 1);
   localparam logic [CW-1:0]    STALL_MAX = CW'(TIMEOUT - 1);

   arb_state_t        state, state_d;
   logic [GID_W-1:0]  ptr;
   logic [LW-1:0]     remaining;
   logic [CW-1:0]     stall_cnt;

   logic [GID_W-1:0]  winner;
   logic              any_req;
   logic [GID_W-1:0]  sel_idx;
   logic [DWIDTH-1:0] sel_flit;
   logic [LW-1:0]     hdr_len;
   logic              owner_valid;
   logic              pop;
   logic              timeout_hit;
   logic              last_body;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (GID_W)
   ) u_pick (
      .req     (req_valid),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state and shared control decode
   always_comb begin
      sel_idx     = (state == IDLE) ? winner : grant_id;
      owner_valid = req_valid[SW'(grant_id)];
      sel_flit    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (sel_idx == GID_W'(k)) sel_flit = req_data[k*DWIDTH +: DWIDTH];
      end
      hdr_len     = sel_flit[LEN_MSB:LEN_LSB];
      pop         = (state == IDLE) ? (any_req && !out_full)
                                    : (owner_valid && !out_full);
      // Abort depends only on the owner's silence, so it wins even
      // while out_full is also holding the stall counter.
      timeout_hit = (state == BODY) && !owner_valid && (stall_cnt == STALL_MAX);
      last_body   = (state == BODY) && pop && (remaining == LW'(1));

      state_d = state;
      case (state)
         IDLE: if (pop && (hdr_len != '0))    state_d = BODY;
         BODY: if (last_body || timeout_hit) state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      req_ready = '0;
      if (pop) req_ready[SW'(sel_idx)] = 1'b1;
      grant_valid = (state == BODY);
   end

   // Datapath and bookkeeping registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data    <= '0;
         out_valid   <= 1'b0;
         grant_id    <= '0;
         err_timeout <= 1'b0;
         ptr         <= PTR_RST;
         remaining   <= '0;
         stall_cnt   <= '0;
      end else begin
         out_valid   <= pop;
         err_timeout <= timeout_hit;
         if (pop) begin
            out_data <= sel_flit;
            grant_id <= sel_idx;
         end
         case (state)
            IDLE: begin
               if (pop) begin
                  stall_cnt <= '0;
                  if (hdr_len == '0) ptr       <= winner;
                  else               remaining <= hdr_len;
               end
            end
            BODY: begin
               if (pop) begin
                  remaining <= remaining - LW'(1);
                  stall_cnt <= '0;
                  if (last_body) ptr <= grant_id;
               end else if (timeout_hit) begin
                  ptr       <= grant_id;
                  remaining <= '0;
                  stall_cnt <= '0;
               end else if (!out_full) begin
                  stall_cnt <= stall_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spine_out_arbiter.sv
module tb_spine_out_arbiter;

   localparam int N  = 11;
   localparam int DW = 16;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_full;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            grant_valid;
   logic [3:0]      grant_id;
   logic            err_timeout;

   spine_out_arbiter #(
      .NUM_REQ (N),
      .DWIDTH  (DW),
      .TIMEOUT (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .out_full    (out_full),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  id;
      logic [15:0] data;
   } beat_t;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   beat_t        exp_q[$];
   logic [15:0]  rq[N][$];
   logic [N-1:0] rdy_s;
   logic         prev_pop;
   int           err_cnt;
   int           gv_cycles;
   int           rdy_cnt[N];
   beat_t        e_m;
   logic [N-1:0] own_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input logic [15:0] d);
      beat_t b;
      b.id   = 4'(id);
      b.data = d;
      exp_q.push_back(b);
   endtask

   // Requester model: pops what the DUT accepted, presents the next flit.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (rdy_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         req_valid[i] = (rq[i].size() > 0);
         req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : 16'h0000;
      end
      rdy_s = '0;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      rdy_s = req_ready;
      if (reset) begin
         check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         check("accept_to_valid", 32'(out_valid), 32'(prev_pop));
         if (grant_valid) begin
            own_m = '0;
            own_m[grant_id] = 1'b1;
            check("packet_lock", 32'(req_ready & ~own_m), 32'd0);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL beat_unexpected: got id %0d data 0x%04h, expected no beat", grant_id, out_data);
            end else begin
               e_m = exp_q.pop_front();
               check("beat_id", 32'(grant_id), 32'(e_m.id));
               check("beat_data", 32'(out_data), 32'(e_m.data));
            end
         end
         for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
         if (err_timeout) err_cnt++;
         if (grant_valid) gv_cycles++;
         prev_pop = |req_ready;
      end else begin
         prev_pop = 1'b0;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_sig(input string name, input bit use_gv, input int budget);
      int t = 0;
      @(negedge clk);
      while (!(use_gv ? grant_valid : out_valid) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(use_gv ? grant_valid : out_valid), 32'd1);
   endtask

   // Expects n consecutive output beats with no bubble.
   task automatic expect_run(input string name, input int n);
      int cnt = 1;
      wait_sig({name, "_start"}, 1'b0, 40);
      for (int k = 1; k < n; k++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check(name, 32'(cnt), 32'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0, g0, r5;
      reset     = 1'b0;
      out_full  = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rdy_s     = '0;
      prev_pop  = 1'b0;
      err_cnt   = 0;
      gv_cycles = 0;
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

      // Reset state
      wait_cycles(3);
      check("rst_out_valid",   32'(out_valid),   32'd0);
      check("rst_grant_valid", 32'(grant_valid), 32'd0);
      check("rst_grant_id",    32'(grant_id),    32'd0);
      check("rst_out_data",    32'(out_data),    32'd0);
      check("rst_err",         32'(err_timeout), 32'd0);
      check("rst_ready",       32'(req_ready),   32'd0);
      reset = 1'b1;

      // Single-flit packet from requester 0
      @(negedge clk);
      rq[0].push_back(16'h0000);
      push_exp(0, 16'h0000);
      wait_cycles(5);
      check("t1_ready_cycles", 32'(rdy_cnt[0]), 32'd1);
      check("t1_grant_valid",  32'(gv_cycles),  32'd0);
      check("t1_drained",      32'(exp_q.size()), 32'd0);

      // Round-robin fairness, all requesters with LEN=0 headers
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         rq[i].push_back(16'((i << 8) | i));
         push_exp(i, 16'((i << 8) | i));
      end
      rq[0].push_back(16'h0005);
      push_exp(0, 16'h0005);
      expect_run("t2_no_gap", 12);
      wait_cycles(2);
      check("t2_drained", 32'(exp_q.size()), 32'd0);

      // Packet lock: 3 sends LEN=3 while 5 waits
      @(negedge clk);
      r5 = rdy_cnt[5];
      rq[3].push_back(16'h0230);
      rq[3].push_back(16'h3331);
      rq[3].push_back(16'h3332);
      rq[3].push_back(16'h3333);
      rq[5].push_back(16'h0501);
      push_exp(3, 16'h0230);
      push_exp(3, 16'h3331);
      push_exp(3, 16'h3332);
      push_exp(3, 16'h3333);
      push_exp(5, 16'h0501);
      expect_run("t3_no_gap", 5);
      wait_cycles(2);
      check("t3_ready5_once", 32'(rdy_cnt[5] - r5), 32'd1);
      check("t3_drained", 32'(exp_q.size()), 32'd0);

      // Backpressure for 5 cycles during a LEN=2 packet
      e0 = err_cnt;
      rq[6].push_back(16'h0620);
      rq[6].push_back(16'h6661);
      rq[6].push_back(16'h6662);
      push_exp(6, 16'h0620);
      push_exp(6, 16'h6661);
      push_exp(6, 16'h6662);
      wait_sig("t4_grant", 1'b1, 40);
      @(posedge clk);
      #1 out_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_stall_ready", 32'(req_ready), 32'd0);
         if (k > 0) check("t4_stall_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1 out_full = 1'b0;
      wait_cycles(5);
      check("t4_no_err", 32'(err_cnt - e0), 32'd0);
      check("t4_drained", 32'(exp_q.size()), 32'd0);

      // Timeout: owner 7 goes silent after a LEN=4 header, 8 is waiting
      e0 = err_cnt;
      g0 = gv_cycles;
      rq[7].push_back(16'h0740);
      rq[8].push_back(16'h0801);
      push_exp(7, 16'h0740);
      push_exp(8, 16'h0801);
      wait_cycles(80);
      check("t5_err_pulses", 32'(err_cnt - e0),   32'd1);
      check("t5_body_cycles", 32'(gv_cycles - g0), 32'd64);
      check("t5_grant_valid", 32'(grant_valid),    32'd0);
      check("t5_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in the middle of a packet
      rq[2].push_back(16'h0250);
      rq[2].push_back(16'h2221);
      push_exp(2, 16'h0250);
      wait_sig("t6_grant", 1'b1, 40);
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid),   32'd0);
      check("t6_async_grant", 32'(grant_valid), 32'd0);
      check("t6_async_id",    32'(grant_id),    32'd0);
      check("t6_async_data",  32'(out_data),    32'd0);
      for (int i = 0; i < N; i++) rq[i].delete();
      wait_cycles(2);
      reset = 1'b1;
      @(negedge clk);
      rq[1].push_back(16'h0104);
      rq[0].push_back(16'h0003);
      push_exp(0, 16'h0003);
      push_exp(1, 16'h0104);
      wait_cycles(6);
      check("t6_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
